serial_unshifter: RTL

- Multi-cycle, one-bit-per-cycle shift unit that performs the inverse direction of each combinational shifter mode.
- SRL undoes SLL, SLL undoes SRA on non-sign bits, and ROL undoes ROR.
- Serves the execute stage for reverse-shift operations; also used by the verification bench to reconstruct shifter inputs from outputs.
- Start/busy/done handshake; the result is held until the next accepted start.

---
 rtl/serial_unshifter_if.sv | 25 ++
 rtl/serial_unshifter.sv | 96 +++++++++
 2 files changed

// File: rtl/serial_unshifter_if.sv
// Handshake and data bundle for the serial unshifter.
// master drives requests; slave (the unshifter) returns status and result.
interface serial_unshifter_if #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
);
  logic               start;
  logic [WIDTH-1:0]   Shift_In;
  logic [SHAMT_W-1:0] Shift_Val;
  logic [1:0]         Mode;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   Shift_Out;
  logic               Zero;

  modport master (
    output start, Shift_In, Shift_Val, Mode,
    input  busy, done, Shift_Out, Zero
  );

  modport slave (
    input  start, Shift_In, Shift_Val, Mode,
    output busy, done, Shift_Out, Zero
  );
endinterface

// File: rtl/serial_unshifter.sv
// One-bit-per-cycle reverse shifter: SRL, SLL and ROL undo the
// combinational SLL, SRA (non-sign bits) and ROR respectively.
// Start/busy/done handshake; result held until the next accepted start.
module serial_unshifter #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_unshifter_if.slave  bus
);
  localparam logic [1:0] M_SRL = 2'b00;
  localparam logic [1:0] M_SLL = 2'b01;
  localparam logic [1:0] M_ROL = 2'b10;
  localparam logic [1:0] M_ILL = 2'b11;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   step;
  logic [SHAMT_W-1:0] count;
  logic [1:0]         mode;
  logic               accept;
  logic               direct;
  logic               last;

  assign accept = (state == IDLE) && bus.start;
  // Zero shift or an illegal mode skips SHIFT and goes straight to DONE.
  assign direct = (bus.Shift_Val == '0) || (bus.Mode == M_ILL);
  assign last   = (count == SHAMT_W'(1));

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);

  // Single 1-bit step of the working register for the latched mode.
  always_comb begin
    step = work;
    case (mode)
      M_SRL:   step = {1'b0, work[WIDTH-1:1]};
      M_SLL:   step = {work[WIDTH-2:0], 1'b0};
      M_ROL:   step = {work[WIDTH-2:0], work[WIDTH-1]};
      default: step = work;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.start) state_d = direct ? DONE : SHIFT;
      SHIFT:   if (last)      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Working datapath and result capture; the result registers only move
  // on the edge that enters DONE, so intermediate values never show.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work          <= '0;
      count         <= '0;
      mode          <= M_SRL;
      bus.Shift_Out <= '0;
      bus.Zero      <= 1'b1;
    end else begin
      case (state)
        IDLE: if (accept) begin
          work  <= bus.Shift_In;
          count <= bus.Shift_Val;
          mode  <= bus.Mode;
          if (direct) begin
            bus.Shift_Out <= (bus.Mode == M_ILL) ? '0 : bus.Shift_In;
            bus.Zero      <= (bus.Mode == M_ILL) || (bus.Shift_In == '0);
          end
        end
        SHIFT: begin
          work  <= step;
          count <= count - SHAMT_W'(1);
          if (last) begin
            bus.Shift_Out <= step;
            bus.Zero      <= (step == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
